// File: rtl/aes_dec_scheduler.sv
// Key-load sequencer and credit-based block admission for the pipelined AES-128 decrypt core.
// Optional watchdog on stalled in-flight blocks: define AES_DEC_SCHED_TIMEOUT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no key active; key_ready high, waiting for a key
// KEY_LOAD | one-cycle core_key_valid pulse, wait counter loaded
// KEY_WAIT | counting out key-expansion latency
// RUN      | key active; blocks admitted while credits remain
// DRAIN    | new key pending; hold data until in-flight blocks retire
module aes_dec_scheduler #(
   parameter int DATA_W  = 128,
   parameter int KEY_L   = 128,
   parameter int KEY_LAT = 12,
   parameter int CREDITS = 16,
   parameter int CNT_W   = 5,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic [KEY_L-1:0]  key_in,
   input  logic              blk_valid,
   output logic              blk_ready,
   input  logic [DATA_W-1:0] blk_data,
   output logic              core_key_valid,
   output logic [KEY_L-1:0]  core_key,
   output logic              core_data_valid,
   output logic [DATA_W-1:0] core_data,
   input  logic              core_valid_out,
   input  logic              credit_return,
   output logic              key_loaded,
   output logic [CNT_W-1:0]  inflight,
   output logic              busy,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      KEY_LOAD,
      KEY_WAIT,
      RUN
   } state_t;

   localparam int WAIT_W = (KEY_LAT > 2) ? $clog2(KEY_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(KEY_LAT - 1);
   localparam logic [CNT_W-1:0]  CREDITS_C = CNT_W'(CREDITS);

   if (TIMEOUT < 1 || (1 << CNT_W) <= CREDITS || KEY_LAT < 2) begin : g_bad_params
      $error("aes_dec_scheduler: illegal parameter set");
   end

   state_t             state, state_nxt;
   logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
   logic [CNT_W-1:0]   credits, credits_nxt;
   logic [CNT_W-1:0]   inflight_q, inflight_nxt;
   logic [KEY_L-1:0]   core_key_q;
   logic [DATA_W-1:0]  core_data_q;
   logic               core_data_valid_q;
   logic               key_loaded_q;
   logic               err_q;

   logic key_rdy, blk_rdy, key_take, loaded_set, loaded_clr;
   logic issue, ret_ok, dec_ok, err_set;
   logic wd_fire;

`ifdef AES_DEC_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_cnt;

   assign wd_fire = (inflight_q != '0) && !core_valid_out && (wd_cnt == WD_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset || wd_fire || core_valid_out || inflight_q == '0)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + WD_W'(1);
   end
`else
   assign wd_fire = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      wait_nxt   = wait_cnt;
      key_rdy    = 1'b0;
      blk_rdy    = 1'b0;
      key_take   = 1'b0;
      loaded_set = 1'b0;
      loaded_clr = 1'b0;
      case (state)
         IDLE: begin
            key_rdy = 1'b1;
            if (key_valid) begin
               key_take  = 1'b1;
               state_nxt = KEY_LOAD;
            end
         end
         KEY_LOAD: begin
            wait_nxt  = WAIT_INIT;
            state_nxt = KEY_WAIT;
         end
         KEY_WAIT: begin
            // Leave as the count reaches zero so blk_ready opens KEY_LAT cycles after the pulse.
            if (wait_cnt <= WAIT_W'(1)) begin
               wait_nxt   = '0;
               loaded_set = 1'b1;
               state_nxt  = RUN;
            end else begin
               wait_nxt = wait_cnt - WAIT_W'(1);
            end
         end
         RUN: begin
            blk_rdy = (credits != '0) && !key_valid;
            if (key_valid)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            key_rdy = (inflight_q == '0);
            if (key_valid && inflight_q == '0) begin
               key_take   = 1'b1;
               loaded_clr = 1'b1;
               state_nxt  = KEY_LOAD;
            end else if (!key_valid) begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (wd_fire) begin
         state_nxt  = IDLE;
         wait_nxt   = '0;
         key_take   = 1'b0;
         loaded_set = 1'b0;
         loaded_clr = 1'b1;
      end
   end

   assign issue   = blk_valid && blk_rdy;
   assign ret_ok  = credit_return && (credits != CREDITS_C);
   assign dec_ok  = core_valid_out && (inflight_q != '0);
   assign err_set = (credit_return && credits == CREDITS_C)
                 || (core_valid_out && inflight_q == '0)
                 || wd_fire;

   always_comb begin
      credits_nxt  = credits;
      inflight_nxt = inflight_q;
      if (issue && !ret_ok)
         credits_nxt = credits - CNT_W'(1);
      else if (!issue && ret_ok)
         credits_nxt = credits + CNT_W'(1);
      if (issue && !dec_ok)
         inflight_nxt = inflight_q + CNT_W'(1);
      else if (!issue && dec_ok)
         inflight_nxt = inflight_q - CNT_W'(1);
      if (wd_fire) begin
         credits_nxt  = CREDITS_C;
         inflight_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         wait_cnt          <= '0;
         credits           <= CREDITS_C;
         inflight_q        <= '0;
         core_key_q        <= '0;
         core_data_q       <= '0;
         core_data_valid_q <= 1'b0;
         key_loaded_q      <= 1'b0;
         err_q             <= 1'b0;
      end else begin
         state             <= state_nxt;
         wait_cnt          <= wait_nxt;
         credits           <= credits_nxt;
         inflight_q        <= inflight_nxt;
         core_data_valid_q <= issue;
         if (key_take)
            core_key_q <= key_in;
         if (issue)
            core_data_q <= blk_data;
         if (loaded_clr)
            key_loaded_q <= 1'b0;
         else if (loaded_set)
            key_loaded_q <= 1'b1;
         if (err_set)
            err_q <= 1'b1;
      end
   end

   assign key_ready       = key_rdy;
   assign blk_ready       = blk_rdy;
   assign core_key_valid  = (state == KEY_LOAD);
   assign core_key        = core_key_q;
   assign core_data_valid = core_data_valid_q;
   assign core_data       = core_data_q;
   assign key_loaded      = key_loaded_q;
   assign inflight        = inflight_q;
   assign busy            = (state != IDLE) || (inflight_q != '0);
   assign err             = err_q;

endmodule

// File: tb/tb_aes_dec_scheduler.sv
// Directed bench for aes_dec_scheduler; a monitor checks core key/data against queued expectations.
module tb_aes_dec_scheduler;
   localparam int DATA_W = 128;
   localparam int KEY_L  = 128;
   localparam int CNT_W  = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              key_valid, key_ready;
   logic [KEY_L-1:0]  key_in;
   logic              blk_valid, blk_ready;
   logic [DATA_W-1:0] blk_data;
   logic              core_key_valid;
   logic [KEY_L-1:0]  core_key;
   logic              core_data_valid;
   logic [DATA_W-1:0] core_data;
   logic              core_valid_out, credit_return;
   logic              key_loaded;
   logic [CNT_W-1:0]  inflight;
   logic              busy, err;

   aes_dec_scheduler dut (
      .clk(clk), .reset(reset),
      .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
      .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
      .core_key_valid(core_key_valid), .core_key(core_key),
      .core_data_valid(core_data_valid), .core_data(core_data),
      .core_valid_out(core_valid_out), .credit_return(credit_return),
      .key_loaded(key_loaded), .inflight(inflight), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] exp_blk[$];
   logic [KEY_L-1:0]  exp_key[$];

   logic s_blk_ready, s_key_ready, s_core_key_valid, s_core_data_valid;
   logic s_key_loaded, s_busy, s_err, hs_key;
   logic [CNT_W-1:0] s_inflight;
   int n_acc = 0;
   int seq = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: snapshot outputs mid-cycle, record handshakes, return just after the edge.
   task automatic tick();
      @(negedge clk);
      s_blk_ready       = blk_ready;
      s_key_ready       = key_ready;
      s_core_key_valid  = core_key_valid;
      s_core_data_valid = core_data_valid;
      s_key_loaded      = key_loaded;
      s_busy            = busy;
      s_err             = err;
      s_inflight        = inflight;
      hs_key            = !reset && key_valid && key_ready;
      if (!reset && blk_valid && blk_ready) begin
         exp_blk.push_back(blk_data);
         n_acc++;
      end
      if (hs_key)
         exp_key.push_back(key_in);
      @(posedge clk);
      #1;
   endtask

   task automatic next_blk();
      seq++;
      blk_data = {64'hC1F0_5EED_0000_0000, 64'(seq)};
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (core_data_valid) begin
            if (exp_blk.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL core_data_unexpected: got %0h expected none", core_data);
            end else begin
               chk("core_data", core_data, exp_blk.pop_front());
            end
         end
         if (core_key_valid) begin
            if (exp_key.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL core_key_unexpected: got %0h expected none", core_key);
            end else begin
               chk("core_key", core_key, exp_key.pop_front());
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int pulses, first_ckv, first_rdy, first_nr, kr_hi;
      reset = 1'b1; key_valid = 1'b0; key_in = '0; blk_valid = 1'b0; blk_data = '0;
      core_valid_out = 1'b0; credit_return = 1'b0;
      tick(); tick();
      chki("rst_blk_ready", int'(s_blk_ready), 0);
      chki("rst_core_key_valid", int'(s_core_key_valid), 0);
      chki("rst_core_data_valid", int'(s_core_data_valid), 0);
      chki("rst_key_loaded", int'(s_key_loaded), 0);
      chki("rst_inflight", int'(s_inflight), 0);
      chki("rst_busy", int'(s_busy), 0);
      chki("rst_err", int'(s_err), 0);
      chk("rst_core_key", core_key, '0);
      chk("rst_core_data", core_data, '0);

      // key load from IDLE
      reset = 1'b0;
      key_valid = 1'b1;
      key_in = 128'h000102030405060708090a0b0c0d0e0f;
      tick();
      chki("key_hs_idle", int'(hs_key), 1);
      key_valid = 1'b0;
      pulses = 0; first_ckv = -1; first_rdy = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (s_core_key_valid) begin
            pulses++;
            if (first_ckv < 0) first_ckv = i;
         end
         if (s_blk_ready && first_rdy < 0) first_rdy = i;
      end
      chki("key_pulse_count", pulses, 1);
      chki("key_pulse_latency", first_ckv, 1);
      chki("key_wait_latency", first_rdy - first_ckv, 12);
      chki("key_loaded_set", int'(s_key_loaded), 1);

      // credit exhaustion
      n_acc = 0; first_nr = -1;
      blk_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         next_blk();
         tick();
         if (!s_blk_ready && first_nr < 0) first_nr = i;
      end
      chki("credit_accept_count", n_acc, 16);
      chki("credit_ready_drop", first_nr, 16);
      chki("credit_inflight", int'(s_inflight), 16);
      n_acc = 0;
      credit_return = 1'b1;
      next_blk();
      tick();
      chki("credit_return_no_comb", int'(s_blk_ready), 0);
      credit_return = 1'b0;
      for (int i = 0; i < 5; i++) begin
         next_blk();
         tick();
      end
      blk_valid = 1'b0;
      chki("credit_one_more", n_acc, 1);
      core_valid_out = 1'b1;
      repeat (17) tick();
      core_valid_out = 1'b0;
      credit_return = 1'b1;
      repeat (16) tick();
      credit_return = 1'b0;
      tick();
      chki("drain1_inflight", int'(s_inflight), 0);
      chki("drain1_err", int'(s_err), 0);

      // key change with 5 blocks in flight
      n_acc = 0;
      blk_valid = 1'b1;
      for (int i = 0; i < 10 && n_acc < 5; i++) begin
         next_blk();
         tick();
      end
      chki("kc_issue5", n_acc, 5);
      n_acc = 0;
      key_valid = 1'b1;
      key_in = 128'hfedcba98765432100123456789abcdef;
      next_blk();
      tick();
      chki("kc_blk_ready_drop", int'(s_blk_ready), 0);
      chki("kc_key_ready_run", int'(s_key_ready), 0);
      kr_hi = 0;
      core_valid_out = 1'b1;
      for (int j = 0; j < 5; j++) begin
         tick();
         if (s_key_ready) kr_hi++;
      end
      core_valid_out = 1'b0;
      chki("kc_key_ready_held", kr_hi, 0);
      tick();
      chki("kc_key_hs", int'(hs_key), 1);
      chki("kc_inflight_zero", int'(s_inflight), 0);
      key_valid = 1'b0;
      blk_valid = 1'b0;
      chki("kc_no_blk_in_drain", n_acc, 0);
      tick();
      chki("kc_key_pulse", int'(s_core_key_valid), 1);
      chki("kc_key_loaded_clr", int'(s_key_loaded), 0);
      for (int i = 0; i < 20 && !s_blk_ready; i++) tick();
      chki("kc_run_again", int'(s_blk_ready), 1);

      // simultaneous issue, retire and credit return (credits 11 here)
      n_acc = 0;
      blk_valid = 1'b1;
      next_blk();
      tick();
      next_blk();
      core_valid_out = 1'b1;
      credit_return = 1'b1;
      tick();
      blk_valid = 1'b0; core_valid_out = 1'b0; credit_return = 1'b0;
      tick();
      chki("sim_issued", n_acc, 2);
      chki("sim_inflight", int'(s_inflight), 1);
      chki("sim_err", int'(s_err), 0);
      n_acc = 0;
      blk_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         next_blk();
         tick();
      end
      blk_valid = 1'b0;
      chki("sim_credits_left", n_acc, 10);
      core_valid_out = 1'b1;
      repeat (11) tick();
      core_valid_out = 1'b0;
      credit_return = 1'b1;
      repeat (16) tick();
      credit_return = 1'b0;
      tick();
      chki("drain2_inflight", int'(s_inflight), 0);
      chki("drain2_err", int'(s_err), 0);

      // protocol errors
      credit_return = 1'b1;
      tick();
      credit_return = 1'b0;
      tick();
      chki("err_credit_overflow", int'(s_err), 1);
      n_acc = 0;
      blk_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         next_blk();
         tick();
      end
      blk_valid = 1'b0;
      chki("credit_saturate", n_acc, 16);
      core_valid_out = 1'b1;
      repeat (16) tick();
      core_valid_out = 1'b0;
      repeat (5) tick();
      chki("err_sticky", int'(s_err), 1);
      reset = 1'b1;
      exp_blk.delete();
      exp_key.delete();
      tick();
      reset = 1'b0;
      tick();
      chki("err_cleared_by_reset", int'(s_err), 0);
      core_valid_out = 1'b1;
      tick();
      core_valid_out = 1'b0;
      tick();
      chki("err_stray_retire", int'(s_err), 1);
      chki("stray_inflight", int'(s_inflight), 0);

`ifdef AES_DEC_SCHED_TIMEOUT_EN
      begin
         int wd_n;
         reset = 1'b1;
         exp_blk.delete();
         exp_key.delete();
         tick();
         reset = 1'b0;
         key_valid = 1'b1;
         key_in = 128'h0f0e0d0c0b0a09080706050403020100;
         tick();
         key_valid = 1'b0;
         for (int i = 0; i < 30 && !s_blk_ready; i++) tick();
         blk_valid = 1'b1;
         next_blk();
         tick();
         blk_valid = 1'b0;
         wd_n = 0;
         for (int i = 0; i < 100 && !s_err; i++) begin
            tick();
            wd_n++;
         end
         chki("wd_err", int'(s_err), 1);
         chki("wd_window", int'(wd_n >= 60 && wd_n <= 70), 1);
         chki("wd_inflight", int'(s_inflight), 0);
         chki("wd_key_ready", int'(s_key_ready), 1);
         chki("wd_key_loaded", int'(s_key_loaded), 0);
         chki("wd_busy", int'(s_busy), 0);
      end
`endif

      tick();
      chki("blk_queue_empty", exp_blk.size(), 0);
      chki("key_queue_empty", exp_key.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
